// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction fetch stage. Owns the program counter, issues word fetches to
// instruction memory, buffers returned words in a small FIFO and presents one
// instruction per cycle to the instruction register. Branch/jump redirects
// clear the buffer and discard any fetch still in flight.
//
// Parameters
//   RESET_PC   PC loaded on reset
//   BUF_DEPTH  FIFO entries and also the cap on in-flight requests
//              (power of two, 2..8)
//
// Ports
//   clk, rst_if_n          clock; asynchronous active-low reset
//   stall                  downstream hold, head instruction is not consumed
//   redirect, redirect_pc  taken branch/jump and its target
//   imem_req, imem_addr    fetch request and word address (= PC)
//   imem_gnt               memory accepted the request this cycle
//   imem_rvalid, imem_rdata  in-order response and its instruction word
//   inst_out, pc_out       instruction and its PC for the instruction register
//   inst_valid             inst_out carries a real fetched instruction
//   misalign_err           sticky: some redirect target had bits [1:0] != 0
//   fsm_state              debug view of the FSM (0 = FETCH, 1 = FLUSH)
//
// Build option
//   IF_BYPASS_EN  when defined, a response arriving while the FIFO is empty
//                 (and not flushing) is presented on inst_out in the same
//                 cycle; it is only written into the FIFO if stalled.
//
// Memory handshake: a request is transferred on a cycle where imem_req and
// imem_gnt are both high; imem_req/imem_addr are held until that happens.
// Every transferred request produces exactly one imem_rvalid pulse later,
// in request order, with no back-pressure on the response side.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_if_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  output logic        misalign_err,
  output logic        fsm_state
);

  localparam int          PW      = $clog2(BUF_DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          run_q;
  logic [31:0]   pc_q;
  logic          misalign_q;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] fifo_count_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   fifo_inst [BUF_DEPTH];
  logic [31:0]   fifo_pc   [BUF_DEPTH];

  logic          fifo_empty;
  logic          rsp_ok;
  logic [31:0]   rsp_pc;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          grant;
  logic          room;

  assign fifo_empty = (fifo_count_q == '0);

  // A response with nothing in flight belongs to a request from before a
  // reset; it is dropped entirely.
  assign rsp_ok = imem_rvalid && (outstanding_q != '0);

  // Outside FLUSH, everything in flight was issued back to back ending at
  // pc_q - 4, so the oldest one (the one responding now) is at
  // pc_q - 4*outstanding. This replaces a separate queue of request PCs.
  assign rsp_pc = pc_q - {{(30 - CW){1'b0}}, outstanding_q, 2'b00};

`ifdef IF_BYPASS_EN
  assign bypass = fifo_empty && rsp_ok && (state_q == FETCH) && !redirect;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that is consumed straight away never enters the FIFO.
  assign push = rsp_ok && (state_q == FETCH) && !redirect && !(bypass && !stall);
  assign pop  = !fifo_empty && !stall && !redirect;

  // Buffered words plus in-flight requests never exceed BUF_DEPTH. The head
  // leaving this cycle frees a slot early, which is what lets a zero-wait
  // memory sustain one fetch per cycle with only two entries.
  assign room     = ({1'b0, fifo_count_q} + {1'b0, outstanding_q}) < DEPTH_W;
  assign imem_req = run_q && (state_q == FETCH) && !redirect &&
                    (room || (!fifo_empty && !stall));
  assign grant    = imem_req && imem_gnt;

  assign outstanding_d = outstanding_q + {{(CW - 1){1'b0}}, grant}
                                       - {{(CW - 1){1'b0}}, rsp_ok};

  assign imem_addr    = pc_q;
  assign misalign_err = misalign_q;
  assign fsm_state    = (state_q == FLUSH);

  // FSM: FLUSH waits out requests issued before a redirect.
  always_ff @(posedge clk or negedge rst_if_n) begin
    if (!rst_if_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: if (redirect && (outstanding_d != '0)) state_d = FLUSH;
      FLUSH: if (outstanding_d == '0) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // PC, counters and FIFO pointers. Redirect wins over push and pop.
  always_ff @(posedge clk or negedge rst_if_n) begin
    if (!rst_if_n) begin
      run_q         <= 1'b0;
      pc_q          <= RESET_PC;
      misalign_q    <= 1'b0;
      outstanding_q <= '0;
      fifo_count_q  <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      run_q         <= 1'b1;
      outstanding_q <= outstanding_d;
      if (redirect) begin
        pc_q         <= {redirect_pc[31:2], 2'b00};
        rd_ptr_q     <= '0;
        wr_ptr_q     <= '0;
        fifo_count_q <= '0;
        if (redirect_pc[1:0] != 2'b00) misalign_q <= 1'b1;
      end else begin
        if (grant) pc_q     <= pc_q + 32'd4;
        if (push)  wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
        fifo_count_q <= fifo_count_q + {{(CW - 1){1'b0}}, push}
                                     - {{(CW - 1){1'b0}}, pop};
      end
    end
  end

  // FIFO storage; contents are qualified by fifo_count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr_q] <= imem_rdata;
      fifo_pc[wr_ptr_q]   <= rsp_pc;
    end
  end

  always_comb begin
    inst_out   = NOP;
    pc_out     = pc_q;
    inst_valid = 1'b0;
    if (!fifo_empty) begin
      inst_out   = fifo_inst[rd_ptr_q];
      pc_out     = fifo_pc[rd_ptr_q];
      inst_valid = 1'b1;
    end else if (bypass) begin
      inst_out   = imem_rdata;
      pc_out     = rsp_pc;
      inst_valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IF_BYPASS_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 2;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_if_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        misalign_err;
  logic        fsm_state;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_if_n(rst_if_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid),
    .misalign_err(misalign_err), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem_q[$];   // addresses granted, awaiting response (in order)
  int          mem_ep[$];  // redirect epoch each request was issued in
  logic [63:0] exp_q[$];   // {pc, inst} expected at the consumer, in order
  int          epoch = 0;
  logic [31:0] exp_pc = RST_PC;
  logic        exp_mis = 1'b0;
  int          delivered = 0;

  bit          rec = 0;
  logic [31:0] h_req[$], h_addr[$], h_vld[$], h_pc[$];
  bit          w_on = 0, w_g_seen = 0, w_d_seen = 0;
  logic [31:0] w_g = '0, w_d = '0;

  bit          st, gn, rv, rd;
  logic [31:0] rpc;
  logic [31:0] p_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic clear_hist();
    h_req.delete(); h_addr.delete(); h_vld.delete(); h_pc.delete();
  endtask

  // One clock cycle: drive inputs just after posedge, check at negedge.
  task automatic cycle(input bit c_st, input bit c_gn, input bit c_rv,
                       input bit c_rd, input logic [31:0] c_rpc, input bit bogus);
    int          live;
    bit          stale, exp_req, exp_v, bog;
    logic [31:0] a;
    int          e;
    logic [63:0] item;
    stall = c_st; imem_gnt = c_gn; redirect = c_rd; redirect_pc = c_rpc;
    imem_rvalid = 1'b0; imem_rdata = '0; bog = 0;
    if (c_rv && mem_q.size() > 0) begin
      imem_rvalid = 1'b1; imem_rdata = mem_data(mem_q[0]);
    end else if (bogus && mem_q.size() == 0) begin
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; bog = 1;
    end
    @(negedge clk);
    live = 0;
    foreach (mem_ep[i]) if (mem_ep[i] == epoch) live++;
    stale = (mem_q.size() > 0) && (mem_ep[0] != epoch);
    exp_v = (exp_q.size() != 0);
    exp_req = !c_rd && !stale && (((live + exp_q.size()) < DEPTH) || (exp_v && !c_st));
    check("buffer_bound", 32'((live + exp_q.size()) <= DEPTH), 32'd1);
    check("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
    check("fsm_flush", {31'b0, fsm_state}, {31'b0, stale});
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (imem_req) check("imem_addr", imem_addr, exp_pc);
    // response from memory
    if (imem_rvalid && !bog) begin
      a = mem_q.pop_front();
      e = mem_ep.pop_front();
      if (e == epoch) exp_q.push_back({a, mem_data(a)});
    end
`ifdef IF_BYPASS_EN
    if (!c_rd) exp_v = (exp_q.size() != 0);
`endif
    check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_v});
    if (!inst_valid) check("inst_nop", inst_out, NOP);
    if (rec) begin
      h_req.push_back({31'b0, imem_req}); h_addr.push_back(imem_addr);
      h_vld.push_back({31'b0, inst_valid}); h_pc.push_back(pc_out);
    end
    // consumer
    if (inst_valid && !c_st && !c_rd) begin
      if (exp_q.size() == 0) begin
        check("spurious_inst", {31'b0, inst_valid}, 32'd0);
      end else begin
        item = exp_q.pop_front();
        check("pc_out", pc_out, item[63:32]);
        check("inst_out", inst_out, item[31:0]);
        delivered++;
        if (w_on && !w_d_seen) begin w_d = pc_out; w_d_seen = 1; end
      end
    end
    // request transfer
    if (imem_req && c_gn) begin
      mem_q.push_back(imem_addr);
      mem_ep.push_back(epoch);
      if (w_on && !w_g_seen) begin w_g = imem_addr; w_g_seen = 1; end
      exp_pc = exp_pc + 32'd4;
    end
    // redirect
    if (c_rd) begin
      epoch++;
      exp_q.delete();
      exp_pc = {c_rpc[31:2], 2'b00};
      if (c_rpc[1:0] != 2'b00) exp_mis = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    check({tag, "_addr"}, imem_addr, RST_PC);
    check({tag, "_inst"}, inst_out, NOP);
    check({tag, "_pc"}, pc_out, RST_PC);
    check({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
    check({tag, "_mis"}, {31'b0, misalign_err}, 32'd0);
  endtask

  task automatic model_reset();
    mem_q.delete(); mem_ep.delete(); exp_q.delete();
    epoch++; exp_pc = RST_PC; exp_mis = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: bench did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : main
    // ---- reset ----
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_if_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // ---- zero-wait memory from reset release ----
    clear_hist(); rec = 1;
    repeat (6) cycle(0, 1, 1, 0, '0, 0);
    rec = 0;
    for (int i = 0; i < 3; i++) begin
      check("start_req", h_req[i], 32'd1);
      check("start_addr", h_addr[i], 32'(4 * i));
    end
    check("first_valid_lo", h_vld[FIRST-1], 32'd0);
    check("first_valid_hi", h_vld[FIRST], 32'd1);
    for (int i = 0; i < 3; i++) check("start_pc_out", h_pc[FIRST+i], 32'(4 * i));

    // ---- stall held 4 cycles ----
    clear_hist(); rec = 1;
    repeat (4) cycle(1, 1, 1, 0, '0, 0);
    rec = 0;
    check("stall_req_drop", h_req[3], 32'd0);
    repeat (8) cycle(0, 1, 1, 0, '0, 0);

    // ---- grant withheld 3 cycles ----
    p_hold = exp_pc;
    clear_hist(); rec = 1;
    repeat (3) cycle(0, 0, 1, 0, '0, 0);
    rec = 0;
    for (int i = 0; i < 3; i++) begin
      check("nogrant_req", h_req[i], 32'd1);
      check("nogrant_addr", h_addr[i], p_hold);
    end
    repeat (4) cycle(0, 1, 1, 0, '0, 0);

    // ---- redirect to 0x100 with two requests outstanding ----
    for (int i = 0; i < 20; i++) begin
      if (mem_q.size() == 0 && exp_q.size() == 0) break;
      cycle(0, 0, 1, 0, '0, 0);
    end
    check("drained", 32'(mem_q.size() + exp_q.size()), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (mem_q.size() >= 2) break;
      cycle(0, 1, 0, 0, '0, 0);
    end
    check("two_outstanding", 32'(mem_q.size()), 32'd2);
    w_on = 1; w_g_seen = 0; w_d_seen = 0;
    clear_hist(); rec = 1;
    cycle(0, 1, 0, 1, 32'h0000_0100, 0);
    repeat (3) cycle(0, 1, 1, 0, '0, 0);
    rec = 0;
    check("flush_valid", h_vld[1], 32'd0);
    check("flush_req1", h_req[1], 32'd0);
    check("flush_req2", h_req[2], 32'd0);
    check("refetch_req", h_req[3], 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (w_d_seen) break;
      cycle(0, 1, 1, 0, '0, 0);
    end
    check("redir_first_grant", w_g, 32'h0000_0100);
    check("redir_first_pc_out", w_d, 32'h0000_0100);
    check("redir_seen", {31'b0, w_d_seen}, 32'd1);
    w_on = 0;

    // ---- PC wrap ----
    cycle(0, 1, 1, 1, 32'hFFFF_FFF8, 0);
    repeat (12) cycle(0, 1, 1, 0, '0, 0);

    // ---- misaligned redirect ----
    w_on = 1; w_g_seen = 0; w_d_seen = 0;
    cycle(0, 1, 1, 1, 32'h0000_0102, 0);
    check("misalign_set", {31'b0, misalign_err}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (w_g_seen) break;
      cycle(0, 1, 1, 0, '0, 0);
    end
    check("misalign_fetch", w_g, 32'h0000_0100);
    w_on = 0;

    // ---- randomized traffic ----
    repeat (2500) begin
      st = ($urandom_range(0, 99) < 30);
      gn = ($urandom_range(0, 99) < 70);
      rv = ($urandom_range(0, 99) < 70);
      rd = ($urandom_range(0, 99) < 3);
      rpc = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: rpc = 32'hFFFF_FFF0;
        default: rpc[1:0] = 2'b00;
      endcase
      cycle(st, gn, rv, rd, rpc, 0);
    end
    check("misalign_sticky", {31'b0, misalign_err}, 32'd1);

    // ---- asynchronous reset mid-operation ----
    repeat (2) cycle(0, 1, 0, 0, '0, 0);
    rst_if_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst_if_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(0, 0, 0, 0, '0, 1);  // stray response with nothing in flight
    repeat (12) cycle(0, 1, 1, 0, '0, 0);

    check("delivery_count", 32'(delivered > 400), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
